// File: rtl/float_sub_32_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (out = A - B), one-bit-per-cycle align/normalise.
// Optional macro FLOAT_SUB_STICKY_ROUND_EN adds a round-to-nearest-even stage; default truncates.
module float_sub_32_seq #(
    parameter int unsigned MAX_ALIGN  = 26,
    parameter logic [31:0] QNAN_VALUE = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        NaN_flag,
    output logic        overflow_flag,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // the result and flags stay frozen while out_valid is high and out_ready is low.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLASSIFY = 3'd1,
        S_ALIGN    = 3'd2,
        S_ARITH    = 3'd3,
        S_NORM     = 3'd4,
        S_ROUND    = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    localparam logic [8:0] MAX_ALIGN_W = 9'(MAX_ALIGN);

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [26:0] sig_l_q, sig_l_d, sig_s_q, sig_s_d;
    logic [8:0]  exp_l_q, exp_l_d, exp_s_q, exp_s_d;
    logic        sign_q, sign_d, sub_q, sub_d;
    logic [31:0] out_q, out_d;
    logic        nan_q, nan_d, ovf_q, ovf_d;

    // Significands carry three extra low bits (guard, round, sticky) below the 24-bit mantissa.
    logic [7:0]  a_exp, b_exp;
    logic        a_nan, b_nan, a_inf, b_inf, a_ge;
    logic [8:0]  a_eff, b_eff, exp_diff;
    logic [26:0] a_sig, b_sig;
    logic [27:0] arith_sum;

    assign a_exp     = op_a_q[30:23];
    assign b_exp     = op_b_q[30:23];
    assign a_nan     = (&a_exp) && (|op_a_q[22:0]);
    assign b_nan     = (&b_exp) && (|op_b_q[22:0]);
    assign a_inf     = (&a_exp) && !(|op_a_q[22:0]);
    assign b_inf     = (&b_exp) && !(|op_b_q[22:0]);
    assign a_eff     = (a_exp == 8'd0) ? 9'd1 : {1'b0, a_exp};
    assign b_eff     = (b_exp == 8'd0) ? 9'd1 : {1'b0, b_exp};
    assign a_sig     = {(a_exp != 8'd0), op_a_q[22:0], 3'b000};
    assign b_sig     = {(b_exp != 8'd0), op_b_q[22:0], 3'b000};
    assign a_ge      = (op_a_q[30:0] >= op_b_q[30:0]);
    assign exp_diff  = exp_l_q - exp_s_q;
    assign arith_sum = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                             : ({1'b0, sig_l_q} + {1'b0, sig_s_q});

    function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [26:0] sig);
        // Hidden bit clear at this point means exponent 1 was reached: a denormal.
        return {s, (sig[26] ? e : 8'd0), sig[25:3]};
    endfunction

`ifdef FLOAT_SUB_STICKY_ROUND_EN
    logic        round_up;
    logic [27:0] round_sum;
    assign round_up  = sig_l_q[2] & (sig_l_q[3] | sig_l_q[1] | sig_l_q[0]);
    assign round_sum = {1'b0, sig_l_q} + {24'd0, round_up, 3'b000};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sig_l_q <= '0;
            sig_s_q <= '0;
            exp_l_q <= '0;
            exp_s_q <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            out_q   <= '0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sig_l_q <= sig_l_d;
            sig_s_q <= sig_s_d;
            exp_l_q <= exp_l_d;
            exp_s_q <= exp_s_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            out_q   <= out_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sig_l_d = sig_l_q;
        sig_s_d = sig_s_q;
        exp_l_d = exp_l_q;
        exp_s_d = exp_s_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        out_d   = out_q;
        nan_d   = nan_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_a_d  = A;
                    op_b_d  = {~B[31], B[30:0]};
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                if (a_nan || b_nan || (a_inf && b_inf && (op_a_q[31] != op_b_q[31]))) begin
                    out_d   = QNAN_VALUE;
                    nan_d   = 1'b1;
                    state_d = S_DONE;
                end else if (a_inf) begin
                    out_d   = op_a_q;
                    state_d = S_DONE;
                end else if (b_inf) begin
                    out_d   = op_b_q;
                    state_d = S_DONE;
                end else begin
                    sig_l_d = a_ge ? a_sig : b_sig;
                    exp_l_d = a_ge ? a_eff : b_eff;
                    sig_s_d = a_ge ? b_sig : a_sig;
                    exp_s_d = a_ge ? b_eff : a_eff;
                    sign_d  = a_ge ? op_a_q[31] : op_b_q[31];
                    sub_d   = op_a_q[31] != op_b_q[31];
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (exp_diff == 9'd0) begin
                    state_d = S_ARITH;
                end else if (exp_diff >= MAX_ALIGN_W) begin
                    sig_s_d = '0;
                    exp_s_d = exp_l_q;
                    state_d = S_ARITH;
                end else begin
                    sig_s_d = {1'b0, sig_s_q[26:2], sig_s_q[1] | sig_s_q[0]};
                    exp_s_d = exp_s_q + 9'd1;
                end
            end
            S_ARITH: begin
                if (arith_sum == 28'd0) begin
                    out_d   = 32'h0000_0000;
                    state_d = S_DONE;
                end else if (arith_sum[27]) begin
                    if (exp_l_q == 9'd254) begin
                        out_d   = {sign_q, 8'hFF, 23'd0};
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sig_l_d = {arith_sum[27:2], arith_sum[1] | arith_sum[0]};
                        exp_l_d = exp_l_q + 9'd1;
                        state_d = S_NORM;
                    end
                end else begin
                    sig_l_d = arith_sum[26:0];
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (!sig_l_q[26] && (exp_l_q > 9'd1)) begin
                    sig_l_d = {sig_l_q[25:0], 1'b0};
                    exp_l_d = exp_l_q - 9'd1;
                end else begin
`ifdef FLOAT_SUB_STICKY_ROUND_EN
                    state_d = S_ROUND;
`else
                    out_d   = pack(sign_q, exp_l_q[7:0], sig_l_q);
                    state_d = S_DONE;
`endif
                end
            end
`ifdef FLOAT_SUB_STICKY_ROUND_EN
            S_ROUND: begin
                if (round_sum[27]) begin
                    if (exp_l_q == 9'd254) begin
                        out_d = {sign_q, 8'hFF, 23'd0};
                        ovf_d = 1'b1;
                    end else begin
                        out_d = pack(sign_q, exp_l_q[7:0] + 8'd1, round_sum[27:1]);
                    end
                end else begin
                    out_d = pack(sign_q, exp_l_q[7:0], round_sum[26:0]);
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    nan_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == S_IDLE);
        out_valid     = (state_q == S_DONE);
        out           = out_q;
        NaN_flag      = nan_q;
        overflow_flag = ovf_q;
        dbg_state     = state_q;
    end

endmodule
